sprite_cmd_encoder: RTL
=======================

# sprite_cmd_encoder

Command-stream transmitter for the sprite display blocks: turns one high-level sprite update request (position, visibility, flip, attributes, commit) into the sequence of 32-bit command words the per-sprite display modules decode from `writedata`. It owns the double-buffer bookkeeping. Updates are always written to the back buffer, and a commit issues the buffer-toggle word that swaps front and back. It sits between the Avalon-side software register interface and the shared `writedata` bus that fans out to all sprite display modules.

## Interface
- `GAP_CYCLES`, default 0: NULL cycles inserted between consecutive command words (0..15).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request (IDLE only).
- `req_component`  in  6  target component ID.
- `req_child`  in  5  child component index.
- `req_visible`  in  1  sprite visible.
- `req_flip`  in  1  horizontal flip.
- `req_x`  in  10  X position.
- `req_y`  in  10  Y position.
- `req_attr`  in  10  attribute field.
- `req_commit`  in  1  issue a buffer toggle after the field words.
- `writedata`  out  32  command word; NULL (32'h0) when not transmitting.
- `write`  out  1  high in cycles where `writedata` carries a real word.
- `front_buffer`  out  1  buffer index currently displayed.
- `busy`  out  1  FSM not IDLE.

## Operation
- Word format: [31:26] component, [25:21] child, [20:17] action, [16:14] action_type, [13] buffer bit, [12:0] data.
- Component 6'b000000 is reserved as NULL. The NULL word is all zeros.
- Field words use action 4'h1 and buffer bit = ~front_buffer, so they always target the back buffer:
  - VIS: type 3'b001, data {visible, flip, 11'b0}.
  - X: type 3'b010, data {3'b0, x}.
  - Y: type 3'b011, data {3'b0, y}.
  - ATTR: type 3'b100, data {3'b0, attr}.
- TOGGLE word: action 4'hF, type 3'b000, buffer bit = ~front_buffer, data 0. `front_buffer` inverts in the same cycle TOGGLE is driven.
- FSM states and transitions:
  - IDLE to VIS on req_valid & req_ready.
  - VIS → X → Y → ATTR.
  - After ATTR: to TOGGLE if commit, else IDLE.
  - TOGGLE → IDLE.
  - A GAP state follows each word when `GAP_CYCLES` > 0. The gap counter counts down from `GAP_CYCLES`-1 to 0 and then advances to the next word state.
- On acceptance, all request fields are latched into a holding register. Request inputs are ignored while busy.
- Requests for component NULL are accepted and dropped: the block returns to IDLE and emits no words.

## Timing
- Reset values (asynchronous, applied immediately, including mid-sequence): `writedata`=0, `write`=0, `front_buffer`=0, `busy`=0, `req_ready`=1, FSM=IDLE, gap counter=0. An in-flight request is lost.
- All outputs are registered.
- Acceptance at edge T. The VIS word is valid from T+1. Word k (0-based) is valid at T+1+k·(1+GAP_CYCLES).
- `write` is high for exactly one cycle per word. `writedata`=NULL in every other cycle.
- `req_ready` returns high the cycle after the last word. Back-to-back requests have a minimum spacing of (words + 1) cycles.
- `busy` = ~`req_ready`.

## Configuration
- `SPRITE_CMD_ATTR_EN` defined: the ATTR word is emitted, giving 4 field words.
- `SPRITE_CMD_ATTR_EN` undefined: the ATTR state is not compiled. Y goes directly to TOGGLE or IDLE, giving 3 field words. `req_attr` is ignored.

## Structure
- Package `sprite_cmd_pkg` holds:
  - field widths and bit positions;
  - the action codes ACT_UPDATE=4'h1 and ACT_TOGGLE=4'hF;
  - the action_type enum (VIS, X, Y, ATTR);
  - the NULL word constant;
  - the FSM state enum.
- One sub-module, `sprite_cmd_pack`: a combinational word packer taking (component, child, action, type, buffer bit, data) and producing the 32-bit word. The FSM drives it and registers its result.

## Test plan
- Reset, GAP=0, ATTR_EN defined. Request comp 6'b001001, child 0, vis 1, flip 0, x 100, y 200, attr 0, commit 1.
  - Expected words on consecutive cycles: 0x24027000, 0x2402A064, 0x2402E0C8, 0x24032000, 0x241E2000.
  - `front_buffer` goes 0→1 with the last word.
- Second identical request after the first: all words carry buffer bit 0 (VIS = 0x24025000, TOGGLE = 0x241E0000). `front_buffer` goes 1→0.
- Request with commit 0: exactly 4 words, no TOGGLE, `front_buffer` unchanged, `req_ready` high on the next cycle.
- GAP_CYCLES=2: words spaced 3 cycles apart, `write` high 1 of 3 cycles, NULL in the gap cycles. `req_valid` held high while busy is not accepted.
- Assert `reset_n` low mid-sequence after the X word: outputs zero immediately, `front_buffer`=0, the next request restarts at VIS.
- ATTR_EN undefined: the first scenario emits 4 words, with 0x24032000 absent.

Source files
------------

// File: rtl/sprite_cmd_pkg.sv
// Shared widths, codes and types for the sprite command encoder.
// SPRITE_CMD_ATTR_EN enables the ATTR field word.
package sprite_cmd_pkg;

  localparam int COMP_W  = 6;
  localparam int CHILD_W = 5;
  localparam int ACT_W   = 4;
  localparam int TYPE_W  = 3;
  localparam int DATA_W  = 13;
  localparam int COORD_W = 10;

  localparam int COMP_LSB  = 26;
  localparam int CHILD_LSB = 21;
  localparam int ACT_LSB   = 17;
  localparam int TYPE_LSB  = 14;
  localparam int BUF_BIT   = 13;

  localparam logic [ACT_W-1:0] ACT_UPDATE = 4'h1;
  localparam logic [ACT_W-1:0] ACT_TOGGLE = 4'hF;

  localparam logic [31:0]       NULL_WORD = 32'h0;
  localparam logic [COMP_W-1:0] COMP_NULL = '0;

  typedef enum logic [TYPE_W-1:0] {
    AT_NONE = 3'b000,
    AT_VIS  = 3'b001,
    AT_X    = 3'b010,
    AT_Y    = 3'b011,
    AT_ATTR = 3'b100
  } act_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VIS,
    S_X,
    S_Y,
`ifdef SPRITE_CMD_ATTR_EN
    S_ATTR,
`endif
    S_TOG,
    S_GAP
  } state_e;

  typedef struct packed {
    logic [COMP_W-1:0]  comp;
    logic [CHILD_W-1:0] child;
    logic               vis;
    logic               flip;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               commit;
  } req_t;

endpackage

// File: rtl/sprite_cmd_pack.sv
// Combinational packer: fields in, 32-bit sprite command word out.
// Part of the sprite_cmd_encoder slice (see SPRITE_CMD_ATTR_EN).
module sprite_cmd_pack
  import sprite_cmd_pkg::*;
(
  input  logic [COMP_W-1:0]  comp_i,
  input  logic [CHILD_W-1:0] child_i,
  input  logic [ACT_W-1:0]   action_i,
  input  act_type_e          type_i,
  input  logic               buf_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic [31:0]        word_o
);

  always_comb begin
    word_o = NULL_WORD;
    word_o[COMP_LSB  +: COMP_W]  = comp_i;
    word_o[CHILD_LSB +: CHILD_W] = child_i;
    word_o[ACT_LSB   +: ACT_W]   = action_i;
    word_o[TYPE_LSB  +: TYPE_W]  = type_i;
    word_o[BUF_BIT]              = buf_i;
    word_o[DATA_W-1:0]           = data_i;
  end

endmodule

// File: rtl/sprite_cmd_encoder.sv
// Sprite update request -> back-buffer command words plus optional toggle.
// Define SPRITE_CMD_ATTR_EN to emit the ATTR field word.
module sprite_cmd_encoder
  import sprite_cmd_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COMP_W-1:0]   req_component,
  input  logic [CHILD_W-1:0]  req_child,
  input  logic                req_visible,
  input  logic                req_flip,
  input  logic [COORD_W-1:0]  req_x,
  input  logic [COORD_W-1:0]  req_y,
  input  logic [COORD_W-1:0]  req_attr,
  input  logic                req_commit,
  output logic [31:0]         writedata,
  output logic                write,
  output logic                front_buffer,
  output logic                busy
);

  localparam logic [3:0] GAP_LD =
    (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_e      st_q, nxt_q, emit_st;
  req_t        hold_q, src;
  logic [3:0]  gap_q;
  logic [31:0] wd_q, word;
  logic        wr_q, front_q, ready_q;

  logic [ACT_W-1:0]  action;
  act_type_e         atype;
  logic [DATA_W-1:0] data;

  function automatic state_e follow(state_e s, logic commit);
    state_e n;
    n = S_IDLE;
    case (s)
      S_VIS: n = S_X;
      S_X:   n = S_Y;
`ifdef SPRITE_CMD_ATTR_EN
      S_Y:    n = S_ATTR;
      S_ATTR: n = commit ? S_TOG : S_IDLE;
`else
      S_Y:   n = commit ? S_TOG : S_IDLE;
`endif
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

`ifdef SPRITE_CMD_ATTR_EN
  logic [COORD_W-1:0] attr_q, attr_src;
  assign attr_src = (st_q == S_IDLE) ? req_attr : attr_q;
`else
  logic unused_attr;
  assign unused_attr = ^req_attr;
`endif

  // In IDLE the first word is packed straight from the inputs.
  always_comb begin
    src = hold_q;
    if (st_q == S_IDLE) begin
      src = '{comp:   req_component,
              child:  req_child,
              vis:    req_visible,
              flip:   req_flip,
              x:      req_x,
              y:      req_y,
              commit: req_commit};
    end
  end

  always_comb begin
    emit_st = follow(st_q, hold_q.commit);
    if (st_q == S_IDLE)
      emit_st = S_VIS;
    else if (st_q == S_GAP)
      emit_st = nxt_q;
  end

  always_comb begin
    action = ACT_UPDATE;
    atype  = AT_NONE;
    data   = '0;
    case (emit_st)
      S_VIS: begin
        atype = AT_VIS;
        data  = {src.vis, src.flip, 11'b0};
      end
      S_X: begin
        atype = AT_X;
        data  = {3'b0, src.x};
      end
      S_Y: begin
        atype = AT_Y;
        data  = {3'b0, src.y};
      end
`ifdef SPRITE_CMD_ATTR_EN
      S_ATTR: begin
        atype = AT_ATTR;
        data  = {3'b0, attr_src};
      end
`endif
      S_TOG: action = ACT_TOGGLE;
      default: action = '0;
    endcase
  end

  sprite_cmd_pack u_pack (
    .comp_i   (src.comp),
    .child_i  (src.child),
    .action_i (action),
    .type_i   (atype),
    .buf_i    (~front_q),
    .data_i   (data),
    .word_o   (word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= S_IDLE;
      nxt_q   <= S_IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      wd_q    <= NULL_WORD;
      wr_q    <= 1'b0;
      front_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef SPRITE_CMD_ATTR_EN
      attr_q  <= '0;
`endif
    end else begin
      wd_q <= NULL_WORD;
      wr_q <= 1'b0;
      case (st_q)
        S_IDLE: begin
          if (req_valid) begin
            hold_q <= src;
`ifdef SPRITE_CMD_ATTR_EN
            attr_q <= req_attr;
`endif
            if (src.comp != COMP_NULL) begin
              wd_q    <= word;
              wr_q    <= 1'b1;
              st_q    <= S_VIS;
              ready_q <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_q == 4'd0) begin
            wd_q <= word;
            wr_q <= 1'b1;
            st_q <= nxt_q;
            if (nxt_q == S_TOG)
              front_q <= ~front_q;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        default: begin
          if (emit_st == S_IDLE) begin
            st_q    <= S_IDLE;
            ready_q <= 1'b1;
          end else if (GAP_CYCLES > 0) begin
            st_q  <= S_GAP;
            nxt_q <= emit_st;
            gap_q <= GAP_LD;
          end else begin
            wd_q <= word;
            wr_q <= 1'b1;
            st_q <= emit_st;
            if (emit_st == S_TOG)
              front_q <= ~front_q;
          end
        end
      endcase
    end
  end

  assign writedata    = wd_q;
  assign write        = wr_q;
  assign front_buffer = front_q;
  assign req_ready    = ready_q;
  assign busy         = ~ready_q;

endmodule
